// File: rtl/fixed_max_pool1d_stream.sv
// Streaming 1-D max-pool: lane-wise signed maximum over POOL_SIZE consecutive
// accepted beats, one registered output beat per window.
module fixed_max_pool1d_stream #(
  parameter int DATA_IN_0_PRECISION_0        = 8,
  parameter int DATA_IN_0_PRECISION_1        = 3,
  parameter int DATA_IN_0_TENSOR_SIZE_DIM_0  = 16,
  parameter int DATA_IN_0_PARALLELISM_DIM_0  = 4,
  parameter int POOL_SIZE                    = 2,
  parameter int DATA_OUT_0_PRECISION_0       = DATA_IN_0_PRECISION_0,
  parameter int DATA_OUT_0_PARALLELISM_DIM_0 = DATA_IN_0_PARALLELISM_DIM_0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_IN_0_PRECISION_0-1:0]  data_in_0 [DATA_IN_0_PARALLELISM_DIM_0-1:0],
  input  logic                              data_in_0_valid,
  output logic                              data_in_0_ready,
  output logic [DATA_OUT_0_PRECISION_0-1:0] data_out_0 [DATA_OUT_0_PARALLELISM_DIM_0-1:0],
  output logic                              data_out_0_valid,
  input  logic                              data_out_0_ready
);

  localparam int W  = DATA_IN_0_PRECISION_0;
  localparam int P  = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int K  = POOL_SIZE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  // A misconfigured instance never accepts input rather than silently corrupting rows.
  localparam bit CFG_OK = (K >= 1) &&
                          (DATA_IN_0_TENSOR_SIZE_DIM_0 % (P * K) == 0) &&
                          (DATA_OUT_0_PRECISION_0 == W) &&
                          (DATA_OUT_0_PARALLELISM_DIM_0 == P) &&
                          (DATA_IN_0_PRECISION_1 <= W);

  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_acc [P-1:0];
  logic [W-1:0]  r_out [P-1:0];
  logic          r_out_valid;

  logic [W-1:0]  w_win [P-1:0];
  logic          w_last;
  logic          w_in_fire;
  logic          w_out_fire;

  assign w_last     = (r_cnt == CW'(K - 1));
  assign w_in_fire  = data_in_0_valid && data_in_0_ready;
  assign w_out_fire = r_out_valid && data_out_0_ready;

  // Only the last beat of a window needs room in the output register.
  assign data_in_0_ready = CFG_OK && (!w_last || !r_out_valid || data_out_0_ready);

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    assign w_win[gi] = ((r_cnt == '0) || ($signed(data_in_0[gi]) > $signed(r_acc[gi])))
                       ? data_in_0[gi] : r_acc[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < P; i++) begin
        r_acc[i] <= '0;
        r_out[i] <= '0;
      end
    end else begin
      if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_fire) begin
        if (w_last) begin
          r_cnt       <= '0;
          r_out       <= w_win;
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          r_acc <= w_win;
        end
      end
    end
  end

  assign data_out_0       = r_out;
  assign data_out_0_valid = r_out_valid;

endmodule

// File: tb/tb_fixed_max_pool1d_stream.sv
// Scoreboard bench: four instances (K=2, K=3/P=2, K=4, K=1) driven with directed
// beats; expected windows are queued at issue time and popped by per-instance monitors.
module tb_fixed_max_pool1d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst4_pulse;
  logic rst4;
  assign rst4 = rst | rst4_pulse;

  int checks = 0;
  int errors = 0;
  int outs3  = 0;

  // ---------------- instance signals ----------------
  logic [7:0] din2 [3:0]; logic v2, rdy2, v2o, ordy2; logic [7:0] dout2 [3:0];
  logic [7:0] din3 [1:0]; logic v3, rdy3, v3o, ordy3; logic [7:0] dout3 [1:0];
  logic [7:0] din4 [3:0]; logic v4, rdy4, v4o, ordy4; logic [7:0] dout4 [3:0];
  logic [7:0] din1 [3:0]; logic v1, rdy1, v1o, ordy1; logic [7:0] dout1 [3:0];

  logic [31:0] o2p, o4p, o1p;
  logic [15:0] o3p;
  assign o2p = {dout2[3], dout2[2], dout2[1], dout2[0]};
  assign o4p = {dout4[3], dout4[2], dout4[1], dout4[0]};
  assign o1p = {dout1[3], dout1[2], dout1[1], dout1[0]};
  assign o3p = {dout3[1], dout3[0]};

  logic [31:0] q2[$];
  logic [15:0] q3[$];
  logic [31:0] q4[$];
  logic [31:0] q1[$];

  fixed_max_pool1d_stream #(.DATA_IN_0_TENSOR_SIZE_DIM_0(16), .DATA_IN_0_PARALLELISM_DIM_0(4),
                            .POOL_SIZE(2)) u_k2 (
    .clk(clk), .rst(rst), .data_in_0(din2), .data_in_0_valid(v2), .data_in_0_ready(rdy2),
    .data_out_0(dout2), .data_out_0_valid(v2o), .data_out_0_ready(ordy2));

  fixed_max_pool1d_stream #(.DATA_IN_0_TENSOR_SIZE_DIM_0(24), .DATA_IN_0_PARALLELISM_DIM_0(2),
                            .POOL_SIZE(3)) u_k3 (
    .clk(clk), .rst(rst), .data_in_0(din3), .data_in_0_valid(v3), .data_in_0_ready(rdy3),
    .data_out_0(dout3), .data_out_0_valid(v3o), .data_out_0_ready(ordy3));

  fixed_max_pool1d_stream #(.DATA_IN_0_TENSOR_SIZE_DIM_0(16), .DATA_IN_0_PARALLELISM_DIM_0(4),
                            .POOL_SIZE(4)) u_k4 (
    .clk(clk), .rst(rst4), .data_in_0(din4), .data_in_0_valid(v4), .data_in_0_ready(rdy4),
    .data_out_0(dout4), .data_out_0_valid(v4o), .data_out_0_ready(ordy4));

  fixed_max_pool1d_stream #(.DATA_IN_0_TENSOR_SIZE_DIM_0(16), .DATA_IN_0_PARALLELISM_DIM_0(4),
                            .POOL_SIZE(1)) u_k1 (
    .clk(clk), .rst(rst), .data_in_0(din1), .data_in_0_valid(v1), .data_in_0_ready(rdy1),
    .data_out_0(dout1), .data_out_0_valid(v1o), .data_out_0_ready(ordy1));

  // ---------------- helpers ----------------
  function automatic logic [31:0] pk4(int a, int b, int c, int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [15:0] pk2(int a, int b);
    return {b[7:0], a[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%h t=%0t", name, act, $time);
    end
  endtask

  task automatic send2(input logic [31:0] b);
    int n = 0;
    for (int i = 0; i < 4; i++) din2[i] = b[8*i +: 8];
    v2 = 1'b1;
    @(negedge clk);
    while (!rdy2 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("k2_accept_timeout", 32'(rdy2), 32'd1);
    @(posedge clk); #1;
    v2 = 1'b0;
  endtask

  task automatic send3(input logic [15:0] b);
    int n = 0;
    for (int i = 0; i < 2; i++) din3[i] = b[8*i +: 8];
    v3 = 1'b1;
    @(negedge clk);
    while (!rdy3 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("k3_accept_timeout", 32'(rdy3), 32'd1);
    @(posedge clk); #1;
    v3 = 1'b0;
  endtask

  task automatic send4(input logic [31:0] b);
    int n = 0;
    for (int i = 0; i < 4; i++) din4[i] = b[8*i +: 8];
    v4 = 1'b1;
    @(negedge clk);
    while (!rdy4 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("k4_accept_timeout", 32'(rdy4), 32'd1);
    @(posedge clk); #1;
    v4 = 1'b0;
  endtask

  // K=1: also checks the beat is presented exactly one cycle after acceptance.
  task automatic send1(input logic [31:0] b);
    int n = 0;
    for (int i = 0; i < 4; i++) din1[i] = b[8*i +: 8];
    v1 = 1'b1;
    @(negedge clk);
    while (!rdy1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("k1_accept_timeout", 32'(rdy1), 32'd1);
    @(posedge clk); #1;
    v1 = 1'b0;
    @(negedge clk);
    chk("k1_latency_valid", 32'(v1o), 32'd1);
    chk("k1_latency_data", o1p, b);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && v2o && ordy2) begin
      if (q2.size() == 0) chk("k2_unexpected_out", o2p, 32'hxxxxxxxx);
      else chk("k2_out", o2p, q2.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && v3o && ordy3) begin
      outs3++;
      if (q3.size() == 0) chk("k3_unexpected_out", 32'(o3p), 32'hxxxxxxxx);
      else chk("k3_out", 32'(o3p), 32'(q3.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst4 && v4o && ordy4) begin
      if (q4.size() == 0) chk("k4_unexpected_out", o4p, 32'hxxxxxxxx);
      else chk("k4_out", o4p, q4.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && v1o && ordy1) begin
      if (q1.size() == 0) chk("k1_unexpected_out", o1p, 32'hxxxxxxxx);
      else chk("k1_out", o1p, q1.pop_front());
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "simulation time limit");
  end

  // ---------------- stimulus ----------------
  logic [31:0] k1_beats [8];
  logic [15:0] k3_beats [12];
  logic [15:0] k3_exp   [4];

  initial begin
    rst = 1'b1; rst4_pulse = 1'b0;
    v2 = 0; v3 = 0; v4 = 0; v1 = 0;
    ordy2 = 1; ordy3 = 1; ordy4 = 1; ordy1 = 1;
    for (int i = 0; i < 4; i++) begin din2[i] = '0; din4[i] = '0; din1[i] = '0; end
    for (int i = 0; i < 2; i++) din3[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_k2_valid", 32'(v2o), 32'd0); chk("rst_k2_data", o2p, 32'd0); chk("rst_k2_ready", 32'(rdy2), 32'd1);
    chk("rst_k3_valid", 32'(v3o), 32'd0); chk("rst_k3_data", 32'(o3p), 32'd0); chk("rst_k3_ready", 32'(rdy3), 32'd1);
    chk("rst_k4_valid", 32'(v4o), 32'd0); chk("rst_k4_data", o4p, 32'd0); chk("rst_k4_ready", 32'(rdy4), 32'd1);
    chk("rst_k1_valid", 32'(v1o), 32'd0); chk("rst_k1_data", o1p, 32'd0); chk("rst_k1_ready", 32'(rdy1), 32'd1);
    @(posedge clk); #1;

    // K=2 basic: valid rises one cycle after the last beat and pulses once.
    q2.push_back(pk4(3, -2, 0, 7));
    send2(pk4(3, -5, 0, 7));
    @(negedge clk);
    chk("k2_basic_no_early_valid", 32'(v2o), 32'd0);
    @(posedge clk); #1;
    send2(pk4(1, -2, -8, 7));
    @(negedge clk);
    chk("k2_basic_latency", 32'(v2o), 32'd1);
    @(negedge clk);
    chk("k2_basic_pulse_once", 32'(v2o), 32'd0);
    @(posedge clk); #1;

    // K=2 signed extremes.
    q2.push_back(pk4(-127, 127, -1, 0));
    send2(pk4(-128, 127, -1, 0));
    send2(pk4(-127, -128, -1, -128));
    repeat (2) @(posedge clk); #1;

    // K=2 back-pressure: window 1 stuck, beat 3 taken, beat 4 stalls until release.
    ordy2 = 1'b0;
    q2.push_back(pk4(10, 25, 30, 41));
    q2.push_back(pk4(-1, 0, -3, -4));
    send2(pk4(10, 20, 30, 40));
    send2(pk4(5, 25, -30, 41));
    send2(pk4(-1, -2, -3, -4));
    for (int i = 0; i < 4; i++) din2[i] = pk4(-5, 0, -3, -100) >> (8*i);
    v2 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("k2_bp_ready_low", 32'(rdy2), 32'd0);
      chk("k2_bp_valid_held", 32'(v2o), 32'd1);
      chk("k2_bp_data_held", o2p, pk4(10, 25, 30, 41));
      @(posedge clk); #1;
    end
    ordy2 = 1'b1;
    @(negedge clk);
    chk("k2_bp_accept_on_release", 32'(rdy2), 32'd1);
    @(posedge clk); #1;
    v2 = 1'b0;
    @(negedge clk);
    chk("k2_bp_window2_consecutive", 32'(v2o), 32'd1);
    repeat (2) @(posedge clk); #1;

    // K=3, P=2 with random valid gaps.
    k3_beats = '{pk2(1, -1), pk2(5, -7), pk2(3, 2),
                 pk2(-128, -128), pk2(-100, 127), pk2(-128, 0),
                 pk2(0, 0), pk2(0, 0), pk2(0, 0),
                 pk2(-3, 9), pk2(-2, 8), pk2(-4, 10)};
    k3_exp   = '{pk2(5, 2), pk2(-100, 127), pk2(0, 0), pk2(-2, 10)};
    for (int w = 0; w < 4; w++) q3.push_back(k3_exp[w]);
    for (int b = 0; b < 12; b++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send3(k3_beats[b]);
    end
    repeat (3) @(posedge clk); #1;
    chk("k3_output_count", 32'(outs3), 32'd4);

    // K=4: full window, then a partial window discarded by reset.
    q4.push_back(pk4(7, 7, 7, 7));
    send4(pk4(7, 7, 7, 7)); send4(pk4(-7, 0, 1, 7)); send4(pk4(7, -1, 7, 2)); send4(pk4(3, 7, 6, 7));
    @(negedge clk);
    chk("k4_pre_rst_valid", 32'(v4o), 32'd1);
    @(posedge clk); #1;
    send4(pk4(50, 51, 52, 53)); send4(pk4(50, 51, 52, 53));
    rst4_pulse = 1'b1;
    @(posedge clk); #1;
    rst4_pulse = 1'b0;
    @(negedge clk);
    chk("k4_rst_valid", 32'(v4o), 32'd0);
    chk("k4_rst_data", o4p, 32'd0);
    @(posedge clk); #1;
    q4.push_back(pk4(-10, -10, -10, -10));
    for (int b = 0; b < 3; b++) begin
      send4(pk4(-10, -10, -10, -10));
      @(negedge clk);
      chk("k4_no_early_out", 32'(v4o), 32'd0);
      @(posedge clk); #1;
    end
    send4(pk4(-10, -10, -10, -10));
    repeat (2) @(posedge clk); #1;

    // K=1 pass-through with a toggling downstream ready.
    k1_beats = '{pk4(1, 2, 3, 4), pk4(-1, -2, -3, -4), pk4(127, -128, 0, 1), pk4(9, 9, 9, 9),
                 pk4(0, 0, 0, 0), pk4(-50, 60, -70, 80), pk4(5, 4, 3, 2), pk4(100, -100, 1, -1)};
    fork
      begin
        repeat (80) begin @(posedge clk); #1; ordy1 = ~ordy1; end
        ordy1 = 1'b1;
      end
    join_none
    for (int b = 0; b < 8; b++) begin
      q1.push_back(k1_beats[b]);
      send1(k1_beats[b]);
      @(posedge clk); #1;
    end
    begin
      int n = 0;
      while (q1.size() != 0 && n < 200) begin @(posedge clk); n++; end
    end
    #1;

    chk("k2_queue_drained", 32'(q2.size()), 32'd0);
    chk("k3_queue_drained", 32'(q3.size()), 32'd0);
    chk("k4_queue_drained", 32'(q4.size()), 32'd0);
    chk("k1_queue_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
